// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - direction encodings, FSM states and screen defaults for the snake head stepper
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int SNAKE_XSCREEN = 160;
  localparam int SNAKE_YSCREEN = 120;
  localparam int SNAKE_DIM     = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SCAN,
    S_DONE
  } state_t;

  // Encodings are chosen so that opposite directions are bitwise complements.
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return ~d;
  endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// rtl/snake_dir_latch.sv - KEY to direction register with fixed priority and reversal guard
module snake_dir_latch
  import snake_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] KEY,
  output logic [1:0] dir
);

  logic [1:0] want;
  logic       pressed;

  always_comb begin
    want    = dir;
    pressed = 1'b0;
    if (!KEY[0]) begin
      want    = DIR_RIGHT;
      pressed = 1'b1;
    end else if (!KEY[1]) begin
      want    = DIR_DOWN;
      pressed = 1'b1;
    end else if (!KEY[2]) begin
      want    = DIR_UP;
      pressed = 1'b1;
    end else if (!KEY[3]) begin
      want    = DIR_LEFT;
      pressed = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      dir <= DIR_RIGHT;
    end else if (pressed && (want != reverse_dir(dir))) begin
      dir <= want;
    end
  end

endmodule

// File: rtl/snake_head_step.sv
// rtl/snake_head_step.sv - next head cell, wall check and serial self-collision scan (SNAKE_WRAP_EN: wrap walls)
module snake_head_step
  import snake_pkg::*;
#(
  parameter int         XSCREEN = SNAKE_XSCREEN,
  parameter int         YSCREEN = SNAKE_YSCREEN,
  parameter int         DIM     = SNAKE_DIM,
  parameter int         MAXLEN  = 4,
  parameter logic [7:0] X0      = 8'd80,
  parameter logic [6:0] Y0      = 7'd60
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [3:0]            KEY,
  input  logic                  step,
  input  logic [2:0]            len,
  input  logic [8*MAXLEN-1:0]   body_x,
  input  logic [7*MAXLEN-1:0]   body_y,
  output logic [7:0]            head_x,
  output logic [6:0]            head_y,
  output logic [1:0]            dir,
  output logic                  busy,
  output logic                  done,
  output logic                  hit_wall,
  output logic                  hit_self
);

`ifdef SNAKE_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  localparam logic [8:0] XLIM   = 9'(XSCREEN - DIM);
  localparam logic [7:0] YLIM   = 8'(YSCREEN - DIM);
  localparam logic [7:0] STEP_X = 8'(DIM);
  localparam logic [6:0] STEP_Y = 7'(DIM);

  state_t     state, state_nxt;
  logic [1:0] wdir;
  logic [7:0] cx, nx, seg_x;
  logic [6:0] cy, ny, seg_y;
  logic [2:0] idx;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       wall, wall_stop, scan_hit, scan_last;

  snake_dir_latch u_dir_latch (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .KEY      (KEY),
    .dir      (dir)
  );

  // Candidate cell; on a wall the coordinate is replaced by its wrap target,
  // which only matters when wrapping is enabled.
  always_comb begin
    sum_x = {1'b0, head_x} + {1'b0, STEP_X};
    sum_y = {1'b0, head_y} + {1'b0, STEP_Y};
    nx    = head_x;
    ny    = head_y;
    wall  = 1'b0;
    unique case (wdir)
      DIR_RIGHT: begin
        wall = sum_x > XLIM;
        nx   = wall ? 8'd0 : sum_x[7:0];
      end
      DIR_DOWN: begin
        wall = sum_y > YLIM;
        ny   = wall ? 7'd0 : sum_y[6:0];
      end
      DIR_UP: begin
        wall = head_y < STEP_Y;
        ny   = wall ? YLIM[6:0] : head_y - STEP_Y;
      end
      DIR_LEFT: begin
        wall = head_x < STEP_X;
        nx   = wall ? XLIM[7:0] : head_x - STEP_X;
      end
    endcase
  end

  assign wall_stop = wall & ~WRAP_EN;

  always_comb begin
    seg_x = '0;
    seg_y = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      if (idx == i[2:0]) begin
        seg_x = body_x[8*(MAXLEN-1-i) +: 8];
        seg_y = body_y[7*(MAXLEN-1-i) +: 7];
      end
    end
  end

  assign scan_hit  = (cx == seg_x) && (cy == seg_y);
  assign scan_last = (idx == (len - 3'd2));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (step && !hit_wall && !hit_self) state_nxt = S_CALC;
      S_CALC: state_nxt = (wall_stop || len <= 3'd2) ? S_DONE : S_SCAN;
      S_SCAN: if (scan_hit || scan_last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
    endcase
  end

  // The head is loaded on entry to DONE so it is valid while done is high.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      head_x   <= X0;
      head_y   <= Y0;
      wdir     <= DIR_RIGHT;
      cx       <= '0;
      cy       <= '0;
      idx      <= '0;
      hit_wall <= 1'b0;
      hit_self <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (state_nxt == S_CALC) wdir <= dir;
        end
        S_CALC: begin
          cx <= nx;
          cy <= ny;
          if (wall_stop) begin
            hit_wall <= 1'b1;
          end else if (len <= 3'd2) begin
            head_x <= nx;
            head_y <= ny;
          end else begin
            idx <= 3'd1;
          end
        end
        S_SCAN: begin
          if (scan_hit) begin
            hit_self <= 1'b1;
          end else if (scan_last) begin
            head_x <= cx;
            head_y <= cy;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_DONE: begin
          idx <= '0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_snake_head_step.sv
// tb/tb_snake_head_step.sv - bench for snake_head_step with a cycle-level reference model
module tb_snake_head_step;

  localparam int XS  = 160;
  localparam int YS  = 120;
  localparam int DIM = 10;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  KEY = 4'hF;
  logic        step = 1'b0;
  logic [2:0]  len = 3'd1;
  logic [31:0] body_x;
  logic [27:0] body_y;
  logic [7:0]  head_x;
  logic [6:0]  head_y;
  logic [1:0]  dir;
  logic        busy, done, hit_wall, hit_self;

  logic [7:0]  bxs [4];
  logic [6:0]  bys [4];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  always_comb begin
    body_x = '0;
    body_y = '0;
    for (int i = 0; i < 4; i++) begin
      body_x[8*(3-i) +: 8] = bxs[i];
      body_y[7*(3-i) +: 7] = bys[i];
    end
  end

  snake_head_step dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .KEY      (KEY),
    .step     (step),
    .len      (len),
    .body_x   (body_x),
    .body_y   (body_y),
    .head_x   (head_x),
    .head_y   (head_y),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .hit_wall (hit_wall),
    .hit_self (hit_self)
  );

  // Reference model: whole move result computed at acceptance, released after its latency.
  int m_hx = 80, m_hy = 60, m_dir = 0, cnt = 0;
  bit m_wall = 0, m_self = 0, m_done = 0;
  int r_hx, r_hy;
  bit r_wall, r_self;
  int rev_tab [4] = '{3, 2, 1, 0};

  always @(posedge CLOCK_50) begin
    int old_dir, nd, cx, cy, k;
    bit pr, was_busy, w, hit;
    if (reset) begin
      m_hx = 80; m_hy = 60; m_dir = 0; cnt = 0;
      m_wall = 0; m_self = 0; m_done = 0;
    end else begin
      old_dir = m_dir;
      pr = 0; nd = m_dir;
      for (int i = 0; i < 4; i++) if (!pr && !KEY[i]) begin pr = 1; nd = i; end
      if (pr && nd != rev_tab[m_dir]) m_dir = nd;
      was_busy = (cnt > 0) || m_done;
      m_done = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (!r_wall && !r_self) begin m_hx = r_hx; m_hy = r_hy; end
          m_wall |= r_wall;
          m_self |= r_self;
          m_done = 1;
        end
      end else if (!was_busy && step && !m_wall && !m_self) begin
        cx = m_hx; cy = m_hy; w = 0;
        case (old_dir)
          0: begin cx = m_hx + DIM; w = cx > XS - DIM; end
          1: begin cy = m_hy + DIM; w = cy > YS - DIM; end
          2: begin cy = m_hy - DIM; w = cy < 0; end
          default: begin cx = m_hx - DIM; w = cx < 0; end
        endcase
`ifdef SNAKE_WRAP_EN
        if (w) begin
          if (cx < 0) cx = XS - DIM; else if (cx > XS - DIM) cx = 0;
          if (cy < 0) cy = YS - DIM; else if (cy > YS - DIM) cy = 0;
          w = 0;
        end
`endif
        k = 0; hit = 0;
        if (!w && len > 2) begin
          for (int i = 1; i <= int'(len) - 2; i++) begin
            if (!hit) begin
              k = i;
              if (int'(bxs[i]) == cx && int'(bys[i]) == cy) hit = 1;
            end
          end
        end
        r_hx = cx; r_hy = cy; r_wall = w; r_self = hit;
        cnt = 1 + k;
      end
    end
  end

  always @(negedge CLOCK_50) begin
    logic [20:0] act, exp;
    if (chk_en) begin
      act = {head_x, head_y, dir, busy, done, hit_wall, hit_self};
      exp = {8'(m_hx), 7'(m_hy), 2'(m_dir), (cnt > 0) || m_done, m_done, m_wall, m_self};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_model t=%0t {hx,hy,dir,busy,done,hw,hs} got %h expected %h", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk_en = 1;
    reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    KEY = k;
    @(negedge CLOCK_50);
    KEY = 4'hF;
  endtask

  task automatic do_step(output int lat);
    lat = -1;
    step = 1'b1;
    @(negedge CLOCK_50);
    step = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge CLOCK_50);
    end
    @(negedge CLOCK_50);
  endtask

  task automatic set_body();
    bxs[0] = 8'd80; bys[0] = 7'd60;
    bxs[1] = 8'd90; bys[1] = 7'd60;
    bxs[2] = 8'd90; bys[2] = 7'd70;
    bxs[3] = 8'd80; bys[3] = 7'd70;
  endtask

  initial begin
    int lat, n;
    for (int i = 0; i < 4; i++) begin bxs[i] = '0; bys[i] = '0; end
    @(negedge CLOCK_50);
    do_reset();
    chk("reset_head_x", head_x, 80);
    chk("reset_head_y", head_y, 60);
    chk("reset_dir", dir, 0);
    chk("reset_busy_done", {busy, done, hit_wall, hit_self}, 0);

    len = 3'd1;
    do_step(lat);
    chk("step1_latency", lat, 2);
    chk("step1_head_x", head_x, 90);
    chk("step1_head_y", head_y, 60);
    chk("model_head_x", m_hx, 90);

    press(4'b0111);
    chk("reverse_ignored", dir, 0);
    press(4'b1101);
    chk("turn_down", dir, 1);
    do_step(lat);
    chk("down_latency", lat, 2);
    chk("down_head_y", head_y, 70);
    press(4'b1011);
    chk("up_reverse_ignored", dir, 1);

    do_reset();
    press(4'b1001);
    chk("key_priority", dir, 1);

    do_reset();
    for (int i = 0; i < 7; i++) do_step(lat);
    chk("walk_head_x", head_x, 150);
    do_step(lat);
`ifdef SNAKE_WRAP_EN
    chk("wrap_latency", lat, 2);
    chk("wrap_head_x", head_x, 0);
    chk("wrap_hit_wall", hit_wall, 0);
    chk("wrap_head_y", head_y, 60);
`else
    chk("wall_latency", lat, 2);
    chk("wall_flag", hit_wall, 1);
    chk("wall_head_x", head_x, 150);
    do_step(lat);
    chk("after_wall_no_done", lat, -1);
`endif

    do_reset();
    set_body();
    len = 3'd4;
    press(4'b1101);
    do_step(lat);
    chk("tail_latency", lat, 4);
    chk("tail_head_y", head_y, 70);
    chk("tail_no_hit", {hit_wall, hit_self}, 0);

    do_reset();
    do_step(lat);
    chk("self_latency", lat, 3);
    chk("self_flag", hit_self, 1);
    chk("self_head_x", head_x, 80);
    do_step(lat);
    chk("after_self_no_done", lat, -1);

    do_reset();
    press(4'b1101);
    n = 0;
    step = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    if (done === 1'b1) n++;
    step = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLOCK_50);
      if (done === 1'b1) n++;
    end
    chk("busy_step_one_done", n, 1);

    do_reset();
    step = 1'b1;
    @(negedge CLOCK_50);
    step = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    chk("abort_outputs", {head_x, head_y, dir, busy, done, hit_wall, hit_self},
        {8'd80, 7'd60, 2'd0, 4'd0});
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLOCK_50);
      if (done === 1'b1) n++;
    end
    chk("abort_no_done", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_head_step.md
Name: snake_head_step

Overview:
- Upstream stage of the snake body shift register. On each move request it does four things:
  - samples the latched direction;
  - computes the next head cell;
  - checks the wall and serially scans the body for self-collision;
  - presents the new head X/Y with a one-cycle done strobe.
- The main FSM fires step in its move state and waits for done before it pulses the shift-register enable.

Parameters:
- XSCREEN, 160, screen width in pixels
- YSCREEN, 120, screen height in pixels
- DIM, 10, segment edge in pixels; also the step size
- MAXLEN, 4, number of body segments on the body buses
- X0, 8'd80, head X after reset
- Y0, 7'd60, head Y after reset

Ports:
- CLOCK_50  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- KEY  input  4  active-low buttons: [0] right, [1] down, [2] up, [3] left
- step  input  1  one-cycle move request
- len  input  3  current body length, 1..MAXLEN
- body_x  input  8*MAXLEN  segment X coords; segment 0 (head) in the MS byte
- body_y  input  7*MAXLEN  segment Y coords, same ordering as body_x
- head_x  output  8  next head X, feeds the shift register data_in
- head_y  output  7  next head Y
- dir  output  2  current direction: 0 right, 1 down, 2 up, 3 left
- busy  output  1  high in every state other than IDLE
- done  output  1  one-cycle strobe when a move result is valid
- hit_wall  output  1  sticky wall-collision flag
- hit_self  output  1  sticky self-collision flag

Behaviour:
- Reset values (one clock):
  - head_x=X0, head_y=Y0, dir=0 (right);
  - busy=0, done=0, hit_wall=0, hit_self=0;
  - FSM in IDLE, scan index=0.
- Reset asserted mid-operation aborts the operation with no done pulse.
- Direction latch (every cycle, independent of the FSM):
  - Key priority is KEY[0] > KEY[1] > KEY[2] > KEY[3].
  - A pressed key whose direction is the reverse of dir is ignored (right/left, up/down).
  - With no key pressed, dir holds.
- FSM states: IDLE, CALC, SCAN, DONE.
  - IDLE:
    - step=1 with both hit flags clear → CALC next cycle; dir is frozen into a working register.
    - step while busy, or while either hit flag is set, is ignored with no done.
  - CALC: register candidate cx/cy = head ± DIM on the frozen direction axis.
    - Wall occurs if right gives cx > XSCREEN-DIM, down gives cy > YSCREEN-DIM, or up/left would go below 0 (current coordinate < DIM, so no unsigned wrap).
    - Wall → set hit_wall, go to DONE.
    - Else if len ≤ 2 → DONE (nothing to scan; the tail vacates its cell).
    - Else idx=1 → SCAN.
  - SCAN: compare {cx,cy} against segment idx, one segment per cycle.
    - Match → set hit_self, go to DONE.
    - Else if idx == len-2 → DONE.
    - Else idx+1.
    - The tail (idx len-1) is never compared.
  - DONE: done=1 for exactly one cycle.
    - head_x/head_y load cx/cy only if neither hit flag is set; otherwise they hold.
    - Next state is IDLE.
- Latency from step to done:
  - 2 cycles for the wall case or len ≤ 2;
  - 2+k cycles, where k = segments scanned (≤ len-2), otherwise.
- Arithmetic is unsigned at 8 bits for X and 7 bits for Y; no result may wrap, which the wall check guarantees.
- body_x/body_y must stay stable from step until done; the caller enforces this by holding its shift enable low until done.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined: walls wrap instead of colliding.
  - Right past XSCREEN-DIM → 0; left from 0 → XSCREEN-DIM.
  - Same rule for Y using YSCREEN.
  - hit_wall is tied to 0.
  - The self-collision scan still runs, on the wrapped candidate.
- Undefined: wall behaviour as specified in Behaviour.

Decomposition:
- Package snake_pkg holds:
  - direction encodings DIR_RIGHT=0, DIR_DOWN=1, DIR_UP=2, DIR_LEFT=3;
  - the reverse-direction function;
  - the FSM state enum;
  - XSCREEN/YSCREEN/DIM defaults.
- One sub-module, snake_dir_latch, holds the KEY → dir register with priority and the reversal guard. It is reused by any future second-player input.

Test Plan:
- Reset, then step with no keys, len=1 → done 2 cycles after step; head=(90,60); flags=0.
- KEY[3] pressed while dir=right → dir stays 0; then KEY[1] → dir=1; step → head_y from 60 to 70.
- head=(150,60), dir=right, step → hit_wall=1, done pulse, head holds at (150,60); a further step gives no done.
- len=4, body = head (80,60), (90,60), (90,70), (80,70); dir=down, step → candidate (80,70) is the tail, not scanned; done at cycle 4, no hit; head=(80,70).
- Same body but candidate equals segment 1 (dir=right from (80,60)) → hit_self=1 at the SCAN cycle; done at cycle 3.
- step asserted while busy, and reset asserted during SCAN → no extra done; all outputs return to reset values the next cycle.
- With SNAKE_WRAP_EN: head=(150,60) right → head=(0,60), hit_wall=0.
